axil_req_arbiter: RTL and testbench

//   Round-robin arbiter sharing one AXI4-Lite master port between N_REQ simple command requesters.

---
 rtl/axil_req_arbiter.sv | 121 ++++++++++++
 tb/tb_axil_req_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_req_arbiter.sv
// axil_req_arbiter: round-robin arbiter serialising N_REQ register commands onto one AXI4-Lite master port.
module axil_req_arbiter #(
    parameter int N_REQ          = 2,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [N_REQ-1:0]                  req_valid,
    output logic [N_REQ-1:0]                  req_ready,
    input  logic [N_REQ-1:0]                  req_write,
    input  logic [N_REQ*AXI_ADDR_WIDTH-1:0]   req_addr,
    input  logic [N_REQ*AXI_DATA_WIDTH-1:0]   req_wdata,
    output logic [N_REQ-1:0]                  rsp_valid,
    output logic [AXI_DATA_WIDTH-1:0]         rsp_rdata,
    output logic                              rsp_err,
    output logic [AXI_ADDR_WIDTH-1:0]         M_AXI_awaddr,
    output logic                              M_AXI_awvalid,
    input  logic                              M_AXI_awready,
    output logic [AXI_DATA_WIDTH-1:0]         M_AXI_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0]       M_AXI_wstrb,
    output logic                              M_AXI_wvalid,
    input  logic                              M_AXI_wready,
    input  logic [1:0]                        M_AXI_bresp,
    input  logic                              M_AXI_bvalid,
    output logic                              M_AXI_bready,
    output logic [AXI_ADDR_WIDTH-1:0]         M_AXI_araddr,
    output logic                              M_AXI_arvalid,
    input  logic                              M_AXI_arready,
    input  logic [AXI_DATA_WIDTH-1:0]         M_AXI_rdata,
    input  logic [1:0]                        M_AXI_rresp,
    input  logic                              M_AXI_rvalid,
    output logic                              M_AXI_rready
);
    localparam int IW = $clog2(N_REQ);
    typedef enum logic [2:0] {IDLE, WR, WR_B, RD_AR, RD_R} state_t;
    state_t state, state_nx;
    logic [IW-1:0] ptr, sel, j;
    logic [AXI_ADDR_WIDTH-1:0] addr;
    logic found, aw_done, w_done;
    int idx;
    assign M_AXI_awaddr = addr;
    assign M_AXI_araddr = addr;
    assign M_AXI_wstrb  = '1;
    // Walk down from the farthest candidate so the one right after ptr wins.
    always_comb begin
        found = 1'b0;
        sel = ptr;
        idx = 0;
        j = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            j = IW'(idx);
            if (req_valid[j]) begin
                found = 1'b1;
                sel = j;
            end
        end
    end
    always_comb begin
        state_nx = state;
        req_ready = '0;
        M_AXI_bready = state == WR_B;
        M_AXI_rready = state == RD_R;
        aw_done = !M_AXI_awvalid || M_AXI_awready;
        w_done = !M_AXI_wvalid || M_AXI_wready;
        case (state)
            IDLE: if (found) begin
                req_ready[sel] = 1'b1;
                state_nx = req_write[sel] ? WR : RD_AR;
            end
            WR:      if (aw_done && w_done) state_nx = WR_B;
            WR_B:    if (M_AXI_bvalid) state_nx = IDLE;
            RD_AR:   if (M_AXI_arready) state_nx = RD_R;
            RD_R:    if (M_AXI_rvalid) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else state <= state_nx;
    end
    // ptr doubles as the id of the transaction in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= IW'(N_REQ - 1);
            addr <= '0;
            M_AXI_wdata <= '0;
            M_AXI_awvalid <= 1'b0;
            M_AXI_wvalid <= 1'b0;
            M_AXI_arvalid <= 1'b0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err <= 1'b0;
        end else begin
            rsp_valid <= '0;
            if (state == IDLE && found) begin
                ptr <= sel;
                addr <= req_addr[sel*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
                M_AXI_wdata <= req_wdata[sel*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
                M_AXI_awvalid <= req_write[sel];
                M_AXI_wvalid <= req_write[sel];
                M_AXI_arvalid <= !req_write[sel];
            end
            if (state == WR && M_AXI_awready) M_AXI_awvalid <= 1'b0;
            if (state == WR && M_AXI_wready) M_AXI_wvalid <= 1'b0;
            if (state == RD_AR && M_AXI_arready) M_AXI_arvalid <= 1'b0;
            if (state == WR_B && M_AXI_bvalid) begin
                rsp_valid <= N_REQ'(1) << ptr;
                rsp_rdata <= '0;
                rsp_err <= M_AXI_bresp > 2'd1;
            end
            if (state == RD_R && M_AXI_rvalid) begin
                rsp_valid <= N_REQ'(1) << ptr;
                rsp_rdata <= M_AXI_rdata;
                rsp_err <= M_AXI_rresp > 2'd1;
            end
        end
    end
endmodule

// File: tb/tb_axil_req_arbiter.sv
// tb_axil_req_arbiter: directed and randomized checks of axil_req_arbiter against a transaction-level model.
module tb_axil_req_arbiter;
    localparam int N = 2, DW = 32, AW = 32;
    logic clk = 1'b0, rst = 1'b1;
    logic [N-1:0] req_valid, req_ready, req_write, rsp_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [DW-1:0] rsp_rdata, wdata, rdata = '0;
    logic rsp_err;
    logic [AW-1:0] awaddr, araddr;
    logic [DW/8-1:0] wstrb;
    logic awvalid, wvalid, arvalid, bready, rready;
    logic awready = 0, wready = 0, arready = 0, bvalid = 0, rvalid = 0;
    logic [1:0] bresp = '0, rresp = '0;

    axil_req_arbiter #(.N_REQ(N), .AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .M_AXI_awaddr(awaddr), .M_AXI_awvalid(awvalid), .M_AXI_awready(awready),
        .M_AXI_wdata(wdata), .M_AXI_wstrb(wstrb), .M_AXI_wvalid(wvalid), .M_AXI_wready(wready),
        .M_AXI_bresp(bresp), .M_AXI_bvalid(bvalid), .M_AXI_bready(bready), .M_AXI_araddr(araddr),
        .M_AXI_arvalid(arvalid), .M_AXI_arready(arready), .M_AXI_rdata(rdata), .M_AXI_rresp(rresp),
        .M_AXI_rvalid(rvalid), .M_AXI_rready(rready));

    always #5 clk = ~clk;

    bit rv[N], rw[N], hold[N], acc[N];
    logic [AW-1:0] ra[N];
    logic [DW-1:0] rd[N];
    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_valid[i] = rv[i];
            req_write[i] = rw[i];
            req_addr[i*AW +: AW] = ra[i];
            req_wdata[i*DW +: DW] = rd[i];
        end
    end

    // Transaction-level model: one command in flight, response the cycle after the last handshake.
    bit busy, cw, aw_p, w_p, ar_p, rsp_exp, rsp_e, rnd;
    int cur, last = N - 1, rsp_id, n_acc, seen_acc;
    logic [31:0] caddr, cdata, rsp_d;
    int vectors, miscompares, n_wonly, n_bad;
    int aw_lat, w_lat, ar_lat, b_lat, r_lat, aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    logic [1:0] resp_code;
    logic [31:0] rd_val;
    typedef struct {int id; logic [DW-1:0] d; bit e;} rsp_t;
    rsp_t rlog[$];
    int glog[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int dec(input logic [N-1:0] v);
        int r = -1;
        for (int i = 0; i < N; i++) if (v[i]) r = (r == -1) ? i : -2;
        return r;
    endfunction

    always @(negedge clk) begin
        int g;
        bit ebr, erd;
        if (!rst) begin
            chk("rst_ctrl", {req_ready, rsp_valid, awvalid, wvalid, arvalid, bready, rready}, 0);
            chk("rst_addr_wdata", {awaddr, wdata}, 0);
            chk("rst_rsp", {rsp_err, rsp_rdata}, 0);
            busy = 0; rsp_exp = 0; last = N - 1; aw_p = 0; w_p = 0; ar_p = 0;
            for (int i = 0; i < N; i++) acc[i] = 0;
        end else begin
            g = -1;
            if (!busy)
                for (int k = 1; k <= N; k++) if (g < 0 && rv[(last + k) % N]) g = (last + k) % N;
            ebr = busy && cw && !aw_p && !w_p;
            erd = busy && !cw && !ar_p;
            chk("req_ready", req_ready, g >= 0 ? 1 << g : 0);
            chk("aw_w_ar_valid", {awvalid, wvalid, arvalid}, {busy && cw && aw_p, busy && cw && w_p, busy && !cw && ar_p});
            chk("b_r_ready", {bready, rready}, {ebr, erd});
            chk("wstrb", wstrb, {DW/8{1'b1}});
            if (busy && cw && aw_p) chk("awaddr", awaddr, caddr);
            if (busy && cw && w_p) chk("wdata", wdata, cdata);
            if (busy && !cw && ar_p) chk("araddr", araddr, caddr);
            chk("rsp_valid", rsp_valid, rsp_exp ? 1 << rsp_id : 0);
            if (rsp_exp) chk("rsp_err_rdata", {rsp_err, rsp_rdata}, {rsp_e, rsp_d});
            if (rsp_valid != 0) rlog.push_back('{dec(rsp_valid), rsp_rdata, rsp_err});
            if (req_ready != 0) glog.push_back(dec(req_ready));
            if (awvalid && !wvalid) n_wonly++;
            if (bready && (awvalid || wvalid)) n_bad++;
            rsp_exp = 0;
            if (busy && cw) begin
                if (ebr && bvalid) begin busy = 0; rsp_exp = 1; rsp_id = cur; rsp_d = 0; rsp_e = bresp[1]; end
                if (aw_p && awready) aw_p = 0;
                if (w_p && wready) w_p = 0;
            end else if (busy) begin
                if (erd && rvalid) begin busy = 0; rsp_exp = 1; rsp_id = cur; rsp_d = rdata; rsp_e = rresp[1]; end
                if (ar_p && arready) ar_p = 0;
            end
            if (g >= 0) begin
                busy = 1; cur = g; cw = rw[g]; caddr = ra[g]; cdata = rd[g];
                aw_p = cw; w_p = cw; ar_p = !cw; last = g; acc[g] = 1; n_acc++;
            end
        end
    end

    task automatic new_cmd(input int i);
        rv[i] = 1; rw[i] = 1'($urandom_range(1)); ra[i] = $urandom & 32'hFFFC; rd[i] = $urandom;
    endtask

    // Slave with per-transaction latencies, plus requester bookkeeping.
    always @(posedge clk) begin
        bit inb, inr;
        #1;
        if (n_acc != seen_acc) begin
            seen_acc = n_acc;
            if (rnd) begin
                aw_lat = $urandom_range(3); w_lat = $urandom_range(3); ar_lat = $urandom_range(3);
                b_lat = $urandom_range(3); r_lat = $urandom_range(3);
                resp_code = 2'($urandom_range(3)); rd_val = $urandom;
            end
        end
        awready = busy && cw && aw_p && aw_cnt >= aw_lat;
        aw_cnt = (busy && cw && aw_p) ? aw_cnt + 1 : 0;
        wready = busy && cw && w_p && w_cnt >= w_lat;
        w_cnt = (busy && cw && w_p) ? w_cnt + 1 : 0;
        arready = busy && !cw && ar_p && ar_cnt >= ar_lat;
        ar_cnt = (busy && !cw && ar_p) ? ar_cnt + 1 : 0;
        inb = busy && cw && !aw_p && !w_p;
        bvalid = inb && b_cnt >= b_lat; bresp = resp_code;
        b_cnt = inb ? b_cnt + 1 : 0;
        inr = busy && !cw && !ar_p;
        rvalid = inr && r_cnt >= r_lat; rdata = rd_val; rresp = resp_code;
        r_cnt = inr ? r_cnt + 1 : 0;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                acc[i] = 0;
                if (hold[i]) new_cmd(i);
                else rv[i] = 0;
            end else if (rnd && !rv[i] && $urandom_range(3) == 0) new_cmd(i);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input int i, input bit w, input logic [31:0] a, input logic [31:0] d);
        rv[i] = 1; rw[i] = w; ra[i] = a; rd[i] = d;
    endtask

    task automatic expect_rsp(input string nm, input int id, input logic [31:0] d, input bit e);
        int n = 0;
        rsp_t r;
        while (rlog.size() == 0 && n < 100) begin step(); n++; end
        if (rlog.size() == 0) chk({nm, "_timeout"}, 0, 1);
        else begin
            r = rlog.pop_front();
            chk({nm, "_id"}, r.id, id);
            chk({nm, "_rdata"}, r.d, d);
            chk({nm, "_err"}, r.e, e);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        bit any = 1;
        while (any && n < 300) begin
            step(); n++;
            any = busy || rsp_exp;
            for (int i = 0; i < N; i++) any = any || rv[i];
        end
        if (any) chk("drain_timeout", 1, 0);
    endtask

    initial begin
        int n;
        #1 rst = 0;
        repeat (3) @(posedge clk);
        #2 rst = 1;
        b_lat = 2;
        issue(0, 1, 32'h10, 32'hA5A5A5A5);
        expect_rsp("wr0", 0, 32'h0, 0);
        b_lat = 0; r_lat = 1; rd_val = 32'hDEADBEEF;
        step();
        issue(1, 0, 32'h20, 32'h0);
        expect_rsp("rd1", 1, 32'hDEADBEEF, 0);
        wait_idle();
        r_lat = 0; glog.delete();
        hold[0] = 1; hold[1] = 1;
        issue(0, 1, 32'h100, 32'h1); issue(1, 0, 32'h104, 32'h0);
        n = 0;
        while (glog.size() < 4 && n < 200) begin step(); n++; end
        hold[0] = 0; hold[1] = 0;
        wait_idle();
        if (glog.size() < 4) chk("rr_timeout", glog.size(), 4);
        else begin
            chk("rr_g0", glog[0], 0); chk("rr_g1", glog[1], 1);
            chk("rr_g2", glog[2], 0); chk("rr_g3", glog[3], 1);
        end
        rlog.delete();
        n_wonly = 0; n_bad = 0; aw_lat = 3; b_lat = 1;
        issue(0, 1, 32'h44, 32'h12345678);
        expect_rsp("awdly", 0, 32'h0, 0);
        chk("awdly_aw_only_cycles", n_wonly, 3);
        chk("awdly_early_bready", n_bad, 0);
        aw_lat = 0; b_lat = 0; resp_code = 2'b10;
        wait_idle();
        issue(1, 1, 32'h30, 32'h5);
        expect_rsp("slverr", 1, 32'h0, 1);
        resp_code = 2'b00;
        wait_idle();
        rlog.delete();
        r_lat = 1000;
        issue(0, 0, 32'h40, 32'h0);
        n = 0;
        while (!(busy && !cw && !ar_p) && n < 50) begin step(); n++; end
        step();
        chk("pre_rst_rready", rready, 1);
        rst = 0;
        for (int i = 0; i < N; i++) rv[i] = 0;
        #1 chk("rst_drop_ar_r", {arvalid, rready}, 0);
        repeat (2) @(posedge clk);
        #2 rst = 1; r_lat = 0;
        repeat (5) step();
        chk("no_rsp_after_rst", rlog.size(), 0);
        glog.delete();
        issue(0, 0, 32'h50, 32'h0); issue(1, 0, 32'h54, 32'h0);
        wait_idle();
        chk("post_rst_first_grant", glog.size() > 0 ? glog[0] : -1, 0);
        rlog.delete();
        rnd = 1;
        repeat (3000) @(posedge clk);
        rnd = 0;
        wait_idle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
